usb_serial_in_sched: RTL and testbench

//  Packet scheduler for the serial bulk IN endpoint. Drains the system TX FIFO into the
//  usb_fs_pe IN endpoint buffer and decides when to commit a packet: full MAX_PKT packet,

---
 rtl/usb_serial_in_sched.sv | 126 ++++++++++++
 tb/tb_usb_serial_in_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_serial_in_sched.sv
// Serial bulk IN packet scheduler: drains the TX FIFO into the usb_fs_pe IN endpoint buffer
// and commits full packets immediately, short packets after an idle flush time, and a
// zero-length packet when a transfer ends on a full-size packet.
module usb_serial_in_sched #(
   parameter int unsigned MAX_PKT  = 64,
   parameter int unsigned FLUSH_US = 500
) (
   input  logic        clk_48mhz,
   input  logic        reset,
   input  logic        us_tick,
   input  logic        tx_empty,
   input  logic [7:0]  tx_fifo_rdata,
   output logic        tx_read,
   output logic        in_ep_req,
   input  logic        in_ep_grant,
   input  logic        in_ep_data_free,
   output logic        in_ep_data_put,
   output logic [7:0]  in_ep_data,
   output logic        in_ep_data_done,
   output logic        in_ep_stall,
   input  logic        in_ep_acked,
   output logic        busy,
   output logic [15:0] pkt_count
);

   localparam int unsigned    CntW     = $clog2(MAX_PKT + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(MAX_PKT);
   localparam logic [15:0]    FlushVal = 16'(FLUSH_US);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StFill,
      StCommit,
      StWaitAck
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q;
   logic [15:0]     timer_q;
   logic            zlp_pend_q;
   logic            full_q;
   logic            put;
   logic            expired;
   logic            cnt_full;
   logic            cnt_zero;

   // Byte transfer qualifier and next-state decision
   always_comb begin
      expired  = (timer_q == FlushVal);
      cnt_full = (cnt_q == CntMax);
      cnt_zero = (cnt_q == '0);
      put      = (state_q == StFill) && in_ep_grant && in_ep_data_free && !tx_empty &&
                 (cnt_q < CntMax);
      state_d  = state_q;
      unique case (state_q)
         StIdle: begin
            if (!tx_empty || (zlp_pend_q && expired)) state_d = StReq;
         end
         StReq: begin
            if (in_ep_grant) state_d = StFill;
         end
         StFill: begin
            // A put in the same cycle as expiry keeps the packet open.
            if (cnt_full || (expired && !cnt_zero && !put) ||
                (cnt_zero && zlp_pend_q && tx_empty)) begin
               state_d = StCommit;
            end
         end
         StCommit: state_d = StWaitAck;
         StWaitAck: begin
            if (in_ep_acked) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO pop and buffer write strobes follow the put qualifier in the same cycle
   always_comb begin
      tx_read        = put;
      in_ep_data_put = put;
      in_ep_data     = put ? tx_fifo_rdata : 8'h00;
      in_ep_stall    = 1'b0;
   end

   // State, byte count, idle timer, ZLP tracking and registered status outputs
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         timer_q         <= '0;
         zlp_pend_q      <= 1'b0;
         full_q          <= 1'b0;
         pkt_count       <= '0;
         in_ep_req       <= 1'b0;
         in_ep_data_done <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state_q <= state_d;

         if (put || (state_d != state_q) || (state_q == StIdle && !tx_empty)) begin
            timer_q <= '0;
         end else if (us_tick && !expired) begin
            timer_q <= timer_q + 16'd1;
         end

         if (put) cnt_q <= cnt_q + CntW'(1);

         if (state_q == StCommit) begin
            full_q     <= cnt_full;
            zlp_pend_q <= 1'b0;
         end

         if (state_q == StWaitAck && in_ep_acked) begin
            pkt_count  <= pkt_count + 16'd1;
            zlp_pend_q <= full_q;
            cnt_q      <= '0;
         end

         in_ep_req       <= (state_d inside {StReq, StFill, StCommit});
         in_ep_data_done <= (state_d inside {StCommit, StWaitAck});
         busy            <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_usb_serial_in_sched.sv
// Scoreboard bench for usb_serial_in_sched: a behavioural packetiser predicts packet lengths
// and byte order; a monitor checks every put, commit and ACK count against it.
module tb_usb_serial_in_sched;

   localparam int unsigned MaxPkt  = 64;
   localparam int unsigned FlushUs = 100;
   localparam int unsigned TickPer = 3;

   logic        clk_48mhz = 1'b0;
   logic        reset = 1'b0;
   logic        us_tick = 1'b0;
   logic        tx_empty = 1'b1;
   logic [7:0]  tx_fifo_rdata = 8'h00;
   logic        tx_read;
   logic        in_ep_req;
   logic        in_ep_grant = 1'b0;
   logic        in_ep_data_free = 1'b0;
   logic        in_ep_data_put;
   logic [7:0]  in_ep_data;
   logic        in_ep_data_done;
   logic        in_ep_stall;
   logic        in_ep_acked = 1'b0;
   logic        busy;
   logic [15:0] pkt_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  src_q[$];
   logic [7:0]  fifo_q[$];
   logic [7:0]  exp_bytes[$];
   int          exp_len[$];
   bit          model_pend = 0;
   bit          rand_gaps = 0;
   bit          no_gaps = 0;
   bit          force_gap = 0;
   int          spur_req = 0;
   int          spur_done = 0;
   int          cur_cnt = 0;

   usb_serial_in_sched #(
      .MAX_PKT  (MaxPkt),
      .FLUSH_US (FlushUs)
   ) dut (
      .clk_48mhz       (clk_48mhz),
      .reset           (reset),
      .us_tick         (us_tick),
      .tx_empty        (tx_empty),
      .tx_fifo_rdata   (tx_fifo_rdata),
      .tx_read         (tx_read),
      .in_ep_req       (in_ep_req),
      .in_ep_grant     (in_ep_grant),
      .in_ep_data_free (in_ep_data_free),
      .in_ep_data_put  (in_ep_data_put),
      .in_ep_data      (in_ep_data),
      .in_ep_data_done (in_ep_data_done),
      .in_ep_stall     (in_ep_stall),
      .in_ep_acked     (in_ep_acked),
      .busy            (busy),
      .pkt_count       (pkt_count)
   );

   initial forever #5 clk_48mhz = ~clk_48mhz;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // One-cycle microsecond pulse every TickPer clocks
   initial begin : tick_gen
      forever begin
         repeat (TickPer - 1) @(posedge clk_48mhz);
         #1 us_tick = 1'b1;
         @(posedge clk_48mhz);
         #1 us_tick = 1'b0;
      end
   end

   // TX FIFO and endpoint-buffer environment, updated just after each rising edge
   initial begin : env
      logic r;
      logic p;
      int   gap;
      bit   gap_grant;
      gap = 0;
      gap_grant = 0;
      forever begin
         @(negedge clk_48mhz);
         r = in_ep_req;
         p = tx_read;
         @(posedge clk_48mhz);
         #1;
         if (p && !reset && fifo_q.size() > 0) void'(fifo_q.pop_front());
         while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
         tx_empty      = (fifo_q.size() == 0);
         tx_fifo_rdata = tx_empty ? 8'h00 : fifo_q[0];
         if (gap > 0) gap--;
         else if (rand_gaps && $urandom_range(15) == 0) begin
            gap       = $urandom_range(1, 8);
            gap_grant = bit'($urandom_range(1));
         end
         in_ep_grant     = r && !force_gap && !(gap > 0 && gap_grant);
         in_ep_data_free = !force_gap && !(gap > 0 && !gap_grant);
      end
   end

   // Host side: ACK each committed packet after a random delay; optional stray ACKs
   initial begin : host
      forever begin
         @(negedge clk_48mhz);
         if (in_ep_data_done && !reset) begin
            repeat ($urandom_range(1, 6)) @(posedge clk_48mhz);
            #1 in_ep_acked = 1'b1;
            @(posedge clk_48mhz);
            #1 in_ep_acked = 1'b0;
         end else if (spur_req != spur_done) begin
            spur_done++;
            @(posedge clk_48mhz);
            #1 in_ep_acked = 1'b1;
            @(posedge clk_48mhz);
            #1 in_ep_acked = 1'b0;
         end
      end
   end

   // Monitor: checks every cycle, scoreboards bytes and packet commits
   initial begin : monitor
      logic        done_prev;
      logic [15:0] exp_cnt;
      int          ticks, cyc, first_put, last_put, l;
      done_prev = 1'b0;
      exp_cnt = '0;
      ticks = 0;
      cyc = 0;
      first_put = 0;
      last_put = 0;
      forever begin
         @(negedge clk_48mhz);
         cyc++;
         if (reset) begin
            cur_cnt   = 0;
            exp_cnt   = '0;
            done_prev = 1'b0;
            ticks     = 0;
         end else begin
            chk("tx_read_eq_put", 32'(tx_read), 32'(in_ep_data_put));
            chk("put_legal", 32'(in_ep_data_put &&
                !(in_ep_grant && in_ep_data_free && !tx_empty && in_ep_req)), 0);
            chk("stall_zero", 32'(in_ep_stall), 0);
            chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
            if (in_ep_data_put) begin
               if (cur_cnt == 0) first_put = cyc;
               last_put = cyc;
               cur_cnt++;
               ticks = 0;
               chk("byte_expected", 32'(exp_bytes.size() > 0), 1);
               if (exp_bytes.size() > 0) chk("byte_value", 32'(in_ep_data),
                                             32'(exp_bytes.pop_front()));
            end else begin
               chk("data_idle_zero", 32'(in_ep_data), 0);
               if (us_tick) ticks++;
            end
            if (in_ep_data_done && !done_prev) begin
               chk("commit_expected", 32'(exp_len.size() > 0), 1);
               if (exp_len.size() > 0) begin
                  l = exp_len.pop_front();
                  chk("commit_len", 32'(cur_cnt), 32'(l));
                  if (cur_cnt > 0 && cur_cnt < MaxPkt)
                     chk("flush_delay", 32'(ticks >= FlushUs && ticks <= FlushUs + 1), 1);
                  if (cur_cnt == MaxPkt)
                     chk("full_commit_prompt", 32'(cyc - last_put <= 3), 1);
                  if (no_gaps && cur_cnt > 0)
                     chk("puts_consecutive", 32'(last_put - first_put), 32'(cur_cnt - 1));
               end
               cur_cnt = 0;
            end
            if (in_ep_acked && in_ep_data_done) exp_cnt++;
            done_prev = in_ep_data_done;
         end
      end
   end

   // Reference packetiser: whole burst available at once, split into MaxPkt chunks
   task automatic issue_burst(input int n, input bit ascii);
      logic [7:0] b;
      int rem;
      for (int i = 0; i < n; i++) begin
         b = ascii ? 8'(8'h41 + i) : 8'($urandom);
         src_q.push_back(b);
         exp_bytes.push_back(b);
      end
      rem = n;
      while (rem > 0) begin
         exp_len.push_back(rem > MaxPkt ? MaxPkt : rem);
         rem -= MaxPkt;
      end
      model_pend = (n % MaxPkt == 0);
   endtask

   task automatic wait_quiet(input string nm);
      int k;
      k = 0;
      while (!(exp_len.size() == 0 && src_q.size() == 0 && fifo_q.size() == 0 && !busy) &&
             k < 20000) begin
         @(negedge clk_48mhz);
         k++;
      end
      chk({nm, "_quiet"}, 32'(k < 20000), 1);
   endtask

   // Idle longer than the flush time: a pending termination becomes a ZLP
   task automatic settle(input string nm);
      if (model_pend) begin
         exp_len.push_back(0);
         model_pend = 0;
      end
      repeat ((FlushUs + 20) * TickPer) @(negedge clk_48mhz);
      wait_quiet(nm);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_tx_read"}, 32'(tx_read), 0);
      chk({nm, "_req"}, 32'(in_ep_req), 0);
      chk({nm, "_put"}, 32'(in_ep_data_put), 0);
      chk({nm, "_data"}, 32'(in_ep_data), 0);
      chk({nm, "_done"}, 32'(in_ep_data_done), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_pkt_count"}, 32'(pkt_count), 0);
   endtask

   initial begin : stim
      int n;
      int k;
      #1 reset = 1'b1;
      #2 check_reset_outputs("rst0");
      repeat (3) @(posedge clk_48mhz);
      #2 reset = 1'b0;

      // Three ASCII bytes: short packet after flush, no ZLP
      no_gaps = 1;
      issue_burst(3, 1'b1);
      wait_quiet("t1");
      settle("t1s");
      chk("t1_pkt_count", 32'(pkt_count), 1);

      // Exactly one full packet: immediate commit, then ZLP after idle
      issue_burst(64, 1'b0);
      wait_quiet("t2");
      settle("t2s");
      chk("t2_pkt_count", 32'(pkt_count), 3);

      // 130 bytes: 64, 64, 2
      issue_burst(130, 1'b0);
      wait_quiet("t3");
      settle("t3s");
      chk("t3_pkt_count", 32'(pkt_count), 6);

      // Endpoint stalls for 10 cycles mid-fill
      no_gaps = 0;
      issue_burst(40, 1'b0);
      k = 0;
      while (cur_cnt < 10 && k < 2000) begin
         @(negedge clk_48mhz);
         #2 k++;
      end
      chk("t4_fill_started", 32'(cur_cnt >= 10), 1);
      force_gap = 1;
      @(negedge clk_48mhz);
      for (int i = 0; i < 10; i++) begin
         chk("t4_gap_no_put", 32'(in_ep_data_put || tx_read), 0);
         @(negedge clk_48mhz);
      end
      force_gap = 0;
      wait_quiet("t4");
      settle("t4s");
      chk("t4_pkt_count", 32'(pkt_count), 7);

      // Full packet, then one byte well inside the flush window: no ZLP between
      issue_burst(64, 1'b0);
      wait_quiet("t6");
      repeat (20 * TickPer) @(negedge clk_48mhz);
      issue_burst(1, 1'b0);
      wait_quiet("t6b");
      settle("t6s");
      chk("t6_pkt_count", 32'(pkt_count), 9);

      // Stray ACK while idle is ignored
      spur_req++;
      repeat (10) @(negedge clk_48mhz);
      chk("stray_ack_pkt_count", 32'(pkt_count), 9);

      // Random bursts with random endpoint stalls
      rand_gaps = 1;
      for (int i = 0; i < 8; i++) begin
         n = ($urandom_range(3) == 0) ? MaxPkt * $urandom_range(1, 2) : $urandom_range(1, 150);
         issue_burst(n, 1'b0);
         wait_quiet("rnd");
         if ($urandom_range(1) == 1) settle("rnds");
      end
      rand_gaps = 0;
      settle("rndf");

      // Asynchronous reset in the middle of a fill
      issue_burst(40, 1'b0);
      k = 0;
      while (cur_cnt < 20 && k < 2000) begin
         @(negedge clk_48mhz);
         #2 k++;
      end
      chk("t5_fill_reached", 32'(cur_cnt >= 20), 1);
      reset = 1'b1;
      #1 check_reset_outputs("t5rst");
      src_q.delete();
      fifo_q.delete();
      exp_bytes.delete();
      exp_len.delete();
      model_pend = 0;
      repeat (3) @(posedge clk_48mhz);
      #2 reset = 1'b0;
      issue_burst(64, 1'b0);
      wait_quiet("t5");
      settle("t5s");
      chk("t5_pkt_count", 32'(pkt_count), 2);

      chk("leftover_bytes", 32'(exp_bytes.size()), 0);
      chk("leftover_pkts", 32'(exp_len.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
